winograd_acc: RTL
=================

Name: winograd_acc

Overview:
- Downstream consumer of the Winograd pair-product stage.
- Takes the two partial sums that stage produces per 8-element chunk and accumulates them over a variable number of chunks (one dot product).
- Subtracts the precomputed Winograd correction terms: row term sum a[2j]*a[2j+1], column term sum b[2j]*b[2j+1].
- Emits the final signed dot product over a valid/ready handshake. Sits between the pair-product stage and the output buffer.

Parameters:
- PART_SIZE, 21, width of each incoming partial sum; equals the pair-product stage output width ((8+1)*2)+3.
- CORR_SIZE, 24, width of each signed correction term.
- ACC_SIZE, 32, width of accumulator and result; must be >= max(PART_SIZE, CORR_SIZE)+1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  partial-sum beat valid
- ready_o  out  1  block accepts a beat
- last_i  in  1  beat is the final chunk of the dot product
- part_i  in  [1:0][PART_SIZE-1:0]  two signed partial sums from the pair-product stage
- row_corr_i  in  CORR_SIZE  signed row correction, sampled only on the last beat
- col_corr_i  in  CORR_SIZE  signed column correction, sampled only on the last beat
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  ACC_SIZE  signed dot product
- beats_o  out  16  number of beats in the emitted result
- ovf_o  out  1  sticky overflow flag for the emitted result

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state=ACCUM, acc=0, beat count=0.
  - ready_o=1 after release; valid_o=0, result_o=0, beats_o=0, ovf_o=0.
  - Reset mid-operation discards any partial accumulation or pending result.
- Accept = valid_i && ready_o. ready_o is high only in ACCUM (registered from state, no combinational path from ready_i).
- Arithmetic:
  - All operands sign-extended to ACC_SIZE+1.
  - Per beat: acc_next = acc + part_i[0] + part_i[1].
  - Beat count saturates at 16'hFFFF.
- Overflow: flagged when the ACC_SIZE+1 sum differs from sign-extension of its ACC_SIZE truncation. The flag is sticky until the result is consumed.
- States:
  - ACCUM:
    - On accept with last_i=0: update acc, increment count, stay.
    - On accept with last_i=1: update acc, latch row_corr_i and col_corr_i, go to CORRECT.
    - valid_i with ready_o low is not possible in other states; upstream must hold data.
  - CORRECT (1 cycle):
    - result = acc - row - col, using the same overflow rule.
    - Load result_o, beats_o (count including the last beat), ovf_o; set valid_o=1; go to OUTPUT.
  - OUTPUT:
    - result_o, beats_o, ovf_o, valid_o held stable while ready_i=0.
    - On valid_o && ready_i: valid_o=0, acc=0, count=0, ovf cleared, go to ACCUM.
- Latency: last beat accepted at cycle N gives valid_o=1 at cycle N+2. Minimum throughput is one result per (beats+2) cycles when ready_i is tied high.
- Single-beat dot product (last_i on first beat) is legal.
- Zero corrections are legal.
- part_i, row_corr_i and col_corr_i are ignored when not accepted.

Optional Feature:
- Macro WINOGRAD_ACC_SAT_EN.
- Defined:
  - On overflow, the accumulator and result clamp to the most positive value (2^(ACC_SIZE-1)-1) or the most negative value (-2^(ACC_SIZE-1)), according to the sign of the true sum.
  - ovf_o still asserts.
- Undefined: two's-complement wrap to ACC_SIZE bits; ovf_o still reports.

Decomposition:
- Shared package winograd_pkg holds:
  - state enum (ACCUM, CORRECT, OUTPUT);
  - default widths PART_SIZE/CORR_SIZE/ACC_SIZE;
  - the 16-bit beat-count width.
- One sub-module, winograd_sat_add: signed add of two ACC_SIZE+1 operands with overflow detect and optional clamp. It is used for both the accumulate and the correction subtract.

Test Plan:
- Single last beat: part=(10,5), row=4, col=2 -> result_o=9, beats_o=1, ovf_o=0, valid_o two cycles after accept.
- Three beats (10,5),(-3,0),(7,-7) with last on the third, row=4, col=2 -> result_o=6, beats_o=3.
- Backpressure: ready_i=0 for 3 cycles in OUTPUT -> result_o stable, ready_o=0, valid_i ignored; ready_i=1 -> handshake, ready_o=1 next cycle, next result independent of the previous one.
- Overflow, ACC_SIZE=24, 2 beats of (2^22-1, 2^22-1), zero corrections:
  - Wrap build: ovf_o=1, result wraps negative.
  - WINOGRAD_ACC_SAT_EN build: result_o=2^23-1, ovf_o=1.
- Reset mid-operation: rst_ni low for 1 cycle after 2 non-last beats -> next dot product of (1,1) with last, corrections 0 -> result_o=2, beats_o=1.
- Random: 200 dot products of 1-8 beats with random partials, random corrections and random ready_i -> result matches the reference model (sum of partials - row - col, wrapped to ACC_SIZE).

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types and default widths for the Winograd dot-product accumulator.
package winograd_pkg;
  localparam int DEF_PART_SIZE = 21;
  localparam int DEF_CORR_SIZE = 24;
  localparam int DEF_ACC_SIZE  = 32;
  localparam int BEAT_W        = 16;

  typedef enum logic [1:0] {ACCUM, CORRECT, OUTPUT} state_e;
endpackage

// File: rtl/winograd_sat_add.sv
// Signed W+1-bit add with overflow detect; clamps to W bits when WINOGRAD_ACC_SAT_EN is defined.
module winograd_sat_add #(
  parameter int W = 32
) (
  input  logic signed [W:0]   a,
  input  logic signed [W:0]   b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  logic signed [W:0] full;

  assign full = a + b;
  assign ovf  = full[W] != full[W-1];

`ifdef WINOGRAD_ACC_SAT_EN
  // Sign of the true sum lives in the extra top bit.
  assign sum = !ovf   ? full[W-1:0] :
               full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign sum = full[W-1:0];
`endif
endmodule

// File: rtl/winograd_acc.sv
// Accumulates Winograd partial sums over a dot product, subtracts row/column corrections.
// Build option: WINOGRAD_ACC_SAT_EN clamps on overflow instead of wrapping.
module winograd_acc
  import winograd_pkg::*;
#(
  parameter int PART_SIZE = DEF_PART_SIZE,
  parameter int CORR_SIZE = DEF_CORR_SIZE,
  parameter int ACC_SIZE  = DEF_ACC_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       last_i,
  input  logic [1:0][PART_SIZE-1:0]  part_i,
  input  logic [CORR_SIZE-1:0]       row_corr_i,
  input  logic [CORR_SIZE-1:0]       col_corr_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [ACC_SIZE-1:0]        result_o,
  output logic [BEAT_W-1:0]          beats_o,
  output logic                       ovf_o
);
  localparam int AW = ACC_SIZE + 1;

  state_e                state, state_nxt;
  logic [ACC_SIZE-1:0]   acc, sum;
  logic [BEAT_W-1:0]     cnt;
  logic                  ovf_acc, ovf;
  logic [CORR_SIZE-1:0]  row_r, col_r;
  logic signed [AW-1:0]  p0x, p1x, rowx, colx, op_a, op_b;

  assign p0x  = {{(AW-PART_SIZE){part_i[0][PART_SIZE-1]}}, part_i[0]};
  assign p1x  = {{(AW-PART_SIZE){part_i[1][PART_SIZE-1]}}, part_i[1]};
  assign rowx = {{(AW-CORR_SIZE){row_r[CORR_SIZE-1]}}, row_r};
  assign colx = {{(AW-CORR_SIZE){col_r[CORR_SIZE-1]}}, col_r};
  assign op_a = {acc[ACC_SIZE-1], acc};
  // Pair sum and correction sum each fit ACC_SIZE bits, so one adder serves both phases.
  assign op_b = (state == CORRECT) ? -(rowx + colx) : (p0x + p1x);

  winograd_sat_add #(.W(ACC_SIZE)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum),
    .ovf (ovf)
  );

  assign ready_o = (state == ACCUM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ACCUM;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (valid_i && last_i) state_nxt = CORRECT;
      CORRECT: state_nxt = OUTPUT;
      OUTPUT:  if (ready_i) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      row_r    <= '0;
      col_r    <= '0;
      result_o <= '0;
      beats_o  <= '0;
      ovf_o    <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (valid_i) begin
          acc     <= sum;
          ovf_acc <= ovf_acc | ovf;
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (last_i) begin
            row_r <= row_corr_i;
            col_r <= col_corr_i;
          end
        end
        CORRECT: begin
          result_o <= sum;
          beats_o  <= cnt;
          ovf_o    <= ovf_acc | ovf;
          valid_o  <= 1'b1;
        end
        OUTPUT: if (ready_i) begin
          valid_o <= 1'b0;
          acc     <= '0;
          cnt     <= '0;
          ovf_acc <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
